ad7264_frame_sequencer: RTL
===========================

# ad7264_frame_sequencer

SPI master that sequences one AD7264 conversion frame at a time. It drives SS, SCLK and MOSI, shifts out a 16-bit configuration word, and captures the two 14-bit results from MISOA and MISOB. It sits between the SONAR sample-capture logic and the ADC pins, or the bench slave model during bring-up. It paces frames either one per start request or back-to-back in continuous mode.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles; legal values are 1 to 255.
- QUIET, 4: minimum SS-high gap in clk cycles between frames; legal values are 1 to 255.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  while high, a new frame starts automatically after each QUIET gap.
- config_word  in  16  word sent on MOSI, MSB first; latched in the cycle a frame is accepted.
- busy  out  1  high from frame acceptance until the QUIET gap ends.
- done  out  1  one-cycle pulse when data_a and data_b update.
- data_a  out  14  last MISOA result, MSB-first assembly.
- data_b  out  14  last MISOB result.
- SS  out  1  active-low slave select.
- SCLK  out  1  serial clock; idles high.
- MOSI  out  1  serial data to the ADC.
- MISOA, MISOB  in  1  serial data from the ADC.

## Operation
- Reset values: SS=1, SCLK=1, MOSI=0, busy=0, done=0, data_a=0, data_b=0, state=IDLE, and all counters are 0.
- The FSM has five states: IDLE, SETUP, SHIFT, HOLD and QUIET.
- IDLE: start=1 or continuous=1 accepts a frame. It latches config_word, sets busy=1 and moves to SETUP.
- SETUP: SS=0, SCLK=1 and MOSI=config[15] for CLK_DIV cycles, then the FSM moves to SHIFT.
- SHIFT: exactly 33 SCLK periods. Each period is CLK_DIV cycles low followed by CLK_DIV cycles high. Falling edges are numbered k=1..33.
  - A 6-bit edge counter counts the falling edges.
  - A divider counter runs 0..CLK_DIV-1 and toggles SCLK at terminal count.
- MOSI: on rising edge k (k=1..15), MOSI changes to config[15-k]. After rising edge 16 it is 0 for the rest of the frame. The slave samples MOSI on falling edges 1..16.
- MISO capture: MISOA and MISOB are sampled in the clk cycle that SCLK goes high after falling edges k=19..32. They shift into 14-bit shadow registers MSB first. No bits are taken during k=17..18 (three-state) or k=33.
- HOLD: after rising edge 33, SCLK stays 1 for CLK_DIV cycles. Then SS goes to 1. In the same cycle the shadow registers are copied to data_a and data_b, done pulses, and the FSM moves to QUIET.
- QUIET: SS stays 1 for QUIET cycles, then busy goes to 0 and the FSM moves to IDLE. A start or continuous request in that IDLE cycle is accepted immediately.
- A start during busy is ignored; it is not queued.
- Lowering continuous mid-frame does not abort the frame. The frame completes and no further frame starts.
- A config_word change mid-frame has no effect; the latched copy is used.
- Reset asserted mid-frame forces all outputs to their reset values immediately. The partial frame is discarded, data_a and data_b are cleared, and done does not pulse.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE.
- SS falls at cycle 1.
- Falling edge k occurs at cycle 1+CLK_DIV+2·CLK_DIV·(k-1).
- Rising edge k occurs at cycle 1+2·k·CLK_DIV.
- SS rises, and done pulses with data valid, at cycle 1+67·CLK_DIV.
- busy falls at cycle 1+67·CLK_DIV+QUIET.
- The earliest next SS fall is one cycle later.
- Defaults (CLK_DIV=2, QUIET=4): SS low 1..134, done at 135, busy low at 139, next frame SS low at 140 in continuous mode. Frame period is 139 cycles.
- SCLK, SS and MOSI are registered outputs with no combinational path from inputs.
- MISO inputs are sampled directly. Synchronisers are outside this block.

## Test plan
- Single frame with the bench slave model, switches=0x2A5C on both channels, config_word=0xBEEF, defaults:
  - done pulses at cycle 135.
  - data_a = data_b = 14'h2A5C.
  - The slave deserializer reads 0xBEEF.
  - Exactly 33 SCLK falling edges occur while SS is low.
- Edge timing with CLK_DIV=1, QUIET=1: SS low at 1, falling edge 1 at cycle 2, SS high and done at cycle 68, busy low at 69.
- Continuous mode, held high for 3 frames with MISOA data 0x0001, 0x2000, 0x3FFF:
  - Three done pulses 139 cycles apart.
  - The data_a sequence matches.
  - SS stays high for ≥4 cycles between frames.
- start pulsed at cycles 10 and 50 of a busy frame: ignored. Only one done occurs and no extra SS fall.
- Reset asserted at cycle 70 of a frame: SS=1, SCLK=1, MOSI=0, busy=0 and data_a=0 in the same cycle. No done pulses. A start after release runs a full, correct frame.
- MISOA driven with 1 during three-state edges 17..18 and on edge 33, with 0 otherwise: data_a=0, proving those edges are excluded.

Source files
------------

// File: rtl/ad7264_frame_sequencer_if.sv
// ad7264_frame_sequencer_if
//
// Bundles the request/result handshake and the AD7264 serial pins that
// connect the frame sequencer to its user and to the ADC.
//
// Signals:
//   start        request one frame (sampled only while the sequencer is idle)
//   continuous   keep starting frames back-to-back while high
//   config_word  16-bit word shifted out on MOSI, MSB first
//   busy         high from frame acceptance until the quiet gap ends
//   done         one-cycle pulse when data_a/data_b update
//   data_a       last 14-bit MISOA result
//   data_b       last 14-bit MISOB result
//   SS           active-low slave select
//   SCLK         serial clock, idles high
//   MOSI         serial data towards the ADC
//   MISOA/MISOB  serial data from the ADC
//
// Modports:
//   master  the frame sequencer (drives SS/SCLK/MOSI and the results)
//   slave   the counterpart (drives requests and MISO lines)
interface ad7264_frame_sequencer_if;
  logic        start;
  logic        continuous;
  logic [15:0] config_word;
  logic        busy;
  logic        done;
  logic [13:0] data_a;
  logic [13:0] data_b;
  logic        SS;
  logic        SCLK;
  logic        MOSI;
  logic        MISOA;
  logic        MISOB;

  modport master (
    input  start, continuous, config_word, MISOA, MISOB,
    output busy, done, data_a, data_b, SS, SCLK, MOSI
  );

  modport slave (
    output start, continuous, config_word, MISOA, MISOB,
    input  busy, done, data_a, data_b, SS, SCLK, MOSI
  );
endinterface

// File: rtl/ad7264_frame_sequencer.sv
// ad7264_frame_sequencer
//
// SPI master that runs one AD7264 conversion frame at a time: it drops SS,
// clocks out a 16-bit configuration word on MOSI, clocks 33 SCLK periods in
// total and assembles the two 14-bit conversion results from MISOA/MISOB.
// Frames are started one per start request, or back-to-back while
// continuous is high, with a guaranteed SS-high gap of QUIET cycles.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
//   QUIET    minimum SS-high gap in clk cycles between frames (1..255)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    ad7264_frame_sequencer_if master modport (handshake + SPI pins)
module ad7264_frame_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int QUIET   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  ad7264_frame_sequencer_if.master       bus
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);

  localparam logic [5:0] FIRST_DATA_EDGE = 6'd19;
  localparam logic [5:0] LAST_DATA_EDGE  = 6'd32;
  localparam logic [5:0] FINAL_EDGE      = 6'd33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_QUIET
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [7:0]  quiet_cnt;
  logic [5:0]  edge_cnt;
  logic [15:0] cfg_shift;
  logic [13:0] shadow_a;
  logic [13:0] shadow_b;

  logic        ss_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        busy_q;
  logic        done_q;
  logic [13:0] data_a_q;
  logic [13:0] data_b_q;

  // All pin-facing outputs come straight from flops so the ADC never sees
  // a combinational path from start/continuous/MISO.
  assign bus.SS     = ss_q;
  assign bus.SCLK   = sclk_q;
  assign bus.MOSI   = mosi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.data_a = data_a_q;
  assign bus.data_b = data_b_q;

  // Frame sequencer.
  // div_cnt paces every SCLK half-period (and the SETUP/HOLD phases, which
  // are one half-period long). edge_cnt holds the number of the current
  // falling edge k, so the rising edge that ends a low phase is rising edge
  // k: that is where MOSI advances and where MISO bits 19..32 are taken.
  // cfg_shift is the latched configuration word; it is shifted left at each
  // rising edge so MOSI always comes from bit 14 and naturally turns to 0
  // once the 16 configuration bits are gone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      div_cnt   <= 8'd0;
      quiet_cnt <= 8'd0;
      edge_cnt  <= 6'd0;
      cfg_shift <= 16'd0;
      shadow_a  <= 14'd0;
      shadow_b  <= 14'd0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_a_q  <= 14'd0;
      data_b_q  <= 14'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start || bus.continuous) begin
            cfg_shift <= bus.config_word;
            mosi_q    <= bus.config_word[15];
            busy_q    <= 1'b1;
            ss_q      <= 1'b0;
            sclk_q    <= 1'b1;
            div_cnt   <= 8'd0;
            edge_cnt  <= 6'd0;
            shadow_a  <= 14'd0;
            shadow_b  <= 14'd0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            sclk_q   <= 1'b0;
            edge_cnt <= 6'd1;
            state    <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!sclk_q) begin
              sclk_q    <= 1'b1;
              mosi_q    <= cfg_shift[14];
              cfg_shift <= {cfg_shift[14:0], 1'b0};
              if (edge_cnt >= FIRST_DATA_EDGE && edge_cnt <= LAST_DATA_EDGE) begin
                shadow_a <= {shadow_a[12:0], bus.MISOA};
                shadow_b <= {shadow_b[12:0], bus.MISOB};
              end
              if (edge_cnt == FINAL_EDGE) begin
                state <= ST_HOLD;
              end
            end else begin
              sclk_q   <= 1'b0;
              edge_cnt <= edge_cnt + 6'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= 8'd0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            data_a_q  <= shadow_a;
            data_b_q  <= shadow_b;
            done_q    <= 1'b1;
            quiet_cnt <= 8'd0;
            state     <= ST_QUIET;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_QUIET: begin
          if (quiet_cnt == QUIET_LAST) begin
            quiet_cnt <= 8'd0;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            quiet_cnt <= quiet_cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
